// File: rtl/tpu_pkg.sv
// tpu_pkg: shared FSM state type and the optional saturating accumulate (TPU_SAT_EN).
package tpu_pkg;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
`ifdef TPU_SAT_EN
    // Operands arrive sign-extended to 64 bits; the result is clamped to a signed bits-wide range
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int bits);
        logic signed [63:0] s, hi, lo;
        s = a + b;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction
`endif
endpackage

// File: rtl/tpu_if.sv
// tpu_if: host-side bus of the systolic matrix-multiply engine.
interface tpu_if #(parameter int BITS_AB = 8, parameter int BITS_C = 16, parameter int DIM = 4);
    localparam int RW = $clog2(DIM);
    logic start, acc, in_valid, in_ready, busy, done, Cwr_en;
    logic [DIM*BITS_AB-1:0] A_col, B_row;
    logic [RW-1:0] Cwr_row, Crd_row;
    logic [DIM*BITS_C-1:0] Cwr_data, Crd_data;
    modport master(output start, acc, in_valid, A_col, B_row, Cwr_en, Cwr_row, Cwr_data, Crd_row,
                   input in_ready, busy, done, Crd_data);
    modport slave(input start, acc, in_valid, A_col, B_row, Cwr_en, Cwr_row, Cwr_data, Crd_row,
                  output in_ready, busy, done, Crd_data);
endinterface

// File: rtl/tpu_pe.sv
// tpu_pe: signed MAC cell; passes A east and B south, accumulates A*B into Cout.
// TPU_SAT_EN selects a saturating accumulate instead of two's-complement wrap.
module tpu_pe import tpu_pkg::*; #(parameter int BITS_AB = 8, parameter int BITS_C = 16) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic signed [BITS_C-1:0]  wr_data,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
);
    logic signed [2*BITS_AB-1:0] prod;
    logic signed [BITS_C-1:0] sum;
    assign prod = Ain * Bin;
`ifdef TPU_SAT_EN
    assign sum = BITS_C'(sat_add(64'(Cout), 64'(prod), BITS_C));
`else
    assign sum = Cout + BITS_C'(prod);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Aout <= '0;
            Bout <= '0;
            Cout <= '0;
        end else begin
            Aout <= clr ? '0 : en ? Ain : Aout;
            Bout <= clr ? '0 : en ? Bin : Bout;
            Cout <= wr_en ? wr_data : en ? sum : Cout;
        end
    end
endmodule

// File: rtl/tpu_systolic_array.sv
// tpu_systolic_array: DIM x DIM output-stationary signed matrix multiply with input skew and row access.
// Define TPU_SAT_EN for saturating accumulators.
module tpu_systolic_array import tpu_pkg::*; #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 4
) (
    input logic   clk,
    input logic   rst_n,
    tpu_if.slave  bus
);
    localparam int RW = $clog2(DIM);
    localparam int CW = $clog2(2 * DIM);
    localparam logic [CW-1:0] FEED_LAST  = CW'(DIM - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * DIM - 3);
    state_t state;
    logic [CW-1:0] cnt;
    logic go, en, feed;
    logic pe_wr [DIM];
    logic signed [BITS_C-1:0] wd [DIM];
    logic signed [BITS_AB-1:0] a_h [DIM][DIM+1];
    logic signed [BITS_AB-1:0] b_v [DIM+1][DIM];
    logic signed [BITS_C-1:0] c [DIM][DIM];
    logic [DIM*BITS_C-1:0] rd;
    assign go   = state == IDLE && bus.start;
    assign feed = state == FEED;
    assign en   = (feed && bus.in_valid) || state == DRAIN;
    // A clearing start reuses the row-write path with zero data, so start always beats Cwr_en
    always_comb begin
        for (int r = 0; r < DIM; r++)
            pe_wr[r] = go ? !bus.acc : state == IDLE && bus.Cwr_en && bus.Cwr_row == RW'(r);
        for (int j = 0; j < DIM; j++)
            wd[j] = go ? '0 : bus.Cwr_data[j*BITS_C +: BITS_C];
    end
    always_comb begin
        rd = '0;
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++)
                if (bus.Crd_row == RW'(r)) rd[j*BITS_C +: BITS_C] = c[r][j];
    end
    genvar i, j;
    // Row i of A (and column i of B) is delayed by i enabled edges; zeros are injected in DRAIN
    for (i = 0; i < DIM; i++) begin : g_skew
        logic signed [BITS_AB-1:0] a_in, b_in;
        assign a_in = feed ? bus.A_col[i*BITS_AB +: BITS_AB] : '0;
        assign b_in = feed ? bus.B_row[i*BITS_AB +: BITS_AB] : '0;
        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_in;
            assign b_v[0][0] = b_in;
        end else begin : g_delay
            logic signed [BITS_AB-1:0] sa [i];
            logic signed [BITS_AB-1:0] sb [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || go) begin
                    sa <= '{default: '0};
                    sb <= '{default: '0};
                end else if (en) begin
                    sa[0] <= a_in;
                    sb[0] <= b_in;
                    for (int d = 1; d < i; d++) begin
                        sa[d] <= sa[d-1];
                        sb[d] <= sb[d-1];
                    end
                end
            end
            assign a_h[i][0] = sa[i-1];
            assign b_v[0][i] = sb[i-1];
        end
    end
    for (i = 0; i < DIM; i++) begin : g_row
        for (j = 0; j < DIM; j++) begin : g_col
            tpu_pe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_pe (
                .clk(clk), .rst_n(rst_n), .en(en), .clr(go), .wr_en(pe_wr[i]), .wr_data(wd[j]),
                .Ain(a_h[i][j]), .Bin(b_v[i][j]), .Aout(a_h[i][j+1]), .Bout(b_v[i+1][j]), .Cout(c[i][j])
            );
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.Crd_data <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.Crd_data <= rd;
            case (state)
                IDLE: if (bus.start) begin
                    state        <= FEED;
                    cnt          <= '0;
                    bus.busy     <= 1'b1;
                    bus.in_ready <= 1'b1;
                end
                FEED: if (bus.in_valid) begin
                    cnt <= cnt == FEED_LAST ? '0 : cnt + 1'b1;
                    if (cnt == FEED_LAST) begin
                        state        <= DRAIN;
                        bus.in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == DRAIN_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
